// File: rtl/seq_shift_add_mult_if.sv
// Handshake and operand/result bundle for the sequential shift-add multiplier.
// The master side issues start and operands; the slave side returns product, rdy and done.
interface seq_shift_add_mult_if #(
   parameter int WIDTH = 8
);
   logic               start;
   logic               signed_mode;
   logic [WIDTH-1:0]   multiplicand;
   logic [WIDTH-1:0]   multiplier;
   logic [2*WIDTH-1:0] product;
   logic               rdy;
   logic               done;

   modport master (
      output start, signed_mode, multiplicand, multiplier,
      input  product, rdy, done
   );

   modport slave (
      input  start, signed_mode, multiplicand, multiplier,
      output product, rdy, done
   );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: a one-hot IDLE/ADD/SHIFT controller steers an A/B/Q/C/P datapath.
// The unit supports signed and unsigned operands and takes 2*WIDTH+1 cycles from accept to the done strobe.
module seq_shift_add_mult #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input logic clk,
   input logic rst_b,
   seq_shift_add_mult_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      ADD   = 3'b010,
      SHIFT = 3'b100
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [WIDTH-1:0]   q;
   logic               c;
   logic [CNT_W-1:0]   p;
   logic               mode;
   logic               last;
   logic [WIDTH:0]     a_ext;
   logic [WIDTH:0]     b_ext;
   logic [WIDTH:0]     sum;

   // In signed mode the final partial product is weighted by the multiplier's sign bit,
   // so the last ADD subtracts B instead of adding it.
   always_comb begin
      a_ext = {mode & a[WIDTH-1], a};
      b_ext = {mode & b[WIDTH-1], b};
      if (mode && (p == CNT_W'(1)))
         sum = a_ext - b_ext;
      else
         sum = a_ext + b_ext;
   end

   always_ff @(posedge clk) begin
      if (!rst_b)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = ADD;
         ADD:     state_nxt = SHIFT;
         SHIFT:   state_nxt = (p == '0) ? IDLE : ADD;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         a    <= '0;
         b    <= '0;
         q    <= '0;
         c    <= 1'b0;
         p    <= CNT_W'(WIDTH);
         mode <= 1'b0;
         last <= 1'b0;
      end else begin
         last <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a    <= '0;
                  c    <= 1'b0;
                  b    <= bus.multiplicand;
                  q    <= bus.multiplier;
                  p    <= CNT_W'(WIDTH);
                  mode <= bus.signed_mode;
               end
            end
            ADD: begin
               if (q[0])
                  {c, a} <= sum;
               else
                  c <= mode & a[WIDTH-1];
               p <= p - CNT_W'(1);
            end
            SHIFT: begin
               {c, a, q} <= {1'b0, c, a, q[WIDTH-1:1]};
               // Marks the IDLE cycle that follows the final shift.
               last      <= (p == '0);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.rdy     = (state == IDLE);
      bus.done    = (state == IDLE) & last;
      bus.product = {a, q};
   end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult at WIDTH=4 (directed) and WIDTH=8 (random and corner cases).
module tb_seq_shift_add_mult;

   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   seq_shift_add_mult_if #(.WIDTH(4)) bus4 ();
   seq_shift_add_mult_if #(.WIDTH(8)) bus8 ();

   seq_shift_add_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst_b(rst_b), .bus(bus4));
   seq_shift_add_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst_b(rst_b), .bus(bus8));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer product, truncated to 16 bits.
   function automatic logic [15:0] ref8(input logic sm, input logic [7:0] x, input logic [7:0] y);
      longint sx;
      longint sy;
      sx = sm ? longint'($signed(x)) : longint'(x);
      sy = sm ? longint'($signed(y)) : longint'(y);
      return 16'(sx * sy);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mul4(input logic sm, input logic [3:0] x, input logic [3:0] y,
                       output logic [7:0] prod, output int lat, output int busy);
      bus4.signed_mode  = sm;
      bus4.multiplicand = x;
      bus4.multiplier   = y;
      bus4.start        = 1'b1;
      tick();
      bus4.start = 1'b0;
      lat  = 1;
      busy = 0;
      while (!bus4.done && lat < 100) begin
         if (!bus4.rdy) busy++;
         tick();
         lat++;
      end
      prod = bus4.product;
   endtask

   typedef struct {
      logic       sm;
      logic [3:0] x;
      logic [3:0] y;
      logic [7:0] exp;
   } vec4_t;

   initial begin
      vec4_t       v4 [8];
      logic [7:0]  p4;
      logic [15:0] p16;
      logic [15:0] exp16;
      logic        sm;
      logic [7:0]  x;
      logic [7:0]  y;
      int          lat;
      int          busy;
      int          done_cnt;
      int          done_at;
      int          busy_after;

      v4 = '{
         '{1'b0, 4'hF, 4'hF, 8'hE1},
         '{1'b0, 4'h0, 4'hD, 8'h00},
         '{1'b0, 4'h1, 4'h9, 8'h09},
         '{1'b1, 4'hD, 4'h5, 8'hF1},
         '{1'b1, 4'h8, 4'h7, 8'hC8},
         '{1'b1, 4'h8, 4'h8, 8'h40},
         '{1'b1, 4'h7, 4'hF, 8'hF9},
         '{1'b0, 4'hD, 4'h5, 8'h41}
      };

      bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.multiplicand = '0; bus4.multiplier = '0;
      bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.multiplicand = '0; bus8.multiplier = '0;

      // Reset then idle
      rst_b = 1'b0;
      tick();
      tick();
      rst_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("rst_rdy4",  64'(bus4.rdy),     64'(1));
         check("rst_done4", 64'(bus4.done),    64'(0));
         check("rst_prod4", 64'(bus4.product), 64'(0));
         check("rst_rdy8",  64'(bus8.rdy),     64'(1));
         check("rst_done8", 64'(bus8.done),    64'(0));
         check("rst_prod8", 64'(bus8.product), 64'(0));
         tick();
      end

      // WIDTH=4 directed vectors
      for (int i = 0; i < 8; i++) begin
         mul4(v4[i].sm, v4[i].x, v4[i].y, p4, lat, busy);
         check($sformatf("w4_prod_%0d", i), 64'(p4),   64'(v4[i].exp));
         check($sformatf("w4_lat_%0d", i),  64'(lat),  64'(9));
         check($sformatf("w4_busy_%0d", i), 64'(busy), 64'(8));
         tick();
         check($sformatf("w4_pulse_%0d", i), 64'(bus4.done), 64'(0));
         check($sformatf("w4_hold_%0d", i),  64'(bus4.product), 64'(v4[i].exp));
      end

      // WIDTH=8 random, back-to-back starts issued in the done cycle
      for (int i = 0; i < 1000; i++) begin
         if (i == 0) begin
            sm = 1'b1; x = 8'h80; y = 8'h80;
         end else if (i == 1) begin
            sm = 1'b0; x = 8'hFF; y = 8'hFF;
         end else begin
            sm = 1'($urandom_range(0, 1)); x = 8'($urandom); y = 8'($urandom);
         end
         exp16 = ref8(sm, x, y);
         bus8.signed_mode  = sm;
         bus8.multiplicand = x;
         bus8.multiplier   = y;
         bus8.start        = 1'b1;
         tick();
         bus8.start = 1'b0;
         check("b2b_pulse", 64'(bus8.done), 64'(0));
         lat = 1;
         while (!bus8.done && lat < 100) begin
            tick();
            lat++;
         end
         check($sformatf("b2b_lat_%0d", i),  64'(lat),          64'(17));
         check($sformatf("b2b_prod_%0d", i), 64'(bus8.product), 64'(exp16));
      end
      tick();
      check("b2b_end_done", 64'(bus8.done), 64'(0));
      check("b2b_end_rdy",  64'(bus8.rdy),  64'(1));

      // Busy protection: start and operand churn while the unit is busy
      bus8.signed_mode  = 1'b0;
      bus8.multiplicand = 8'd200;
      bus8.multiplier   = 8'd100;
      bus8.start        = 1'b1;
      tick();
      bus8.start = 1'b0;
      done_cnt = 0; done_at = 0; busy_after = 0; p16 = '0;
      for (int c = 1; c <= 40; c++) begin
         if (bus8.done) begin
            done_cnt++;
            done_at = c;
            p16 = bus8.product;
         end else if (done_cnt > 0 && !bus8.rdy) begin
            busy_after++;
         end
         if (c >= 2 && c <= 12) begin
            bus8.start        = c[0];
            bus8.multiplicand = 8'($urandom);
            bus8.multiplier   = 8'($urandom);
            bus8.signed_mode  = ~bus8.signed_mode;
         end else begin
            bus8.start = 1'b0;
         end
         tick();
      end
      check("busy_done_cnt", 64'(done_cnt),   64'(1));
      check("busy_done_at",  64'(done_at),    64'(17));
      check("busy_prod",     64'(p16),        64'(16'h4E20));
      check("busy_rerun",    64'(busy_after), 64'(0));

      // Reset in the 5th cycle of a multiply
      bus8.signed_mode  = 1'b0;
      bus8.multiplicand = 8'h37;
      bus8.multiplier   = 8'h5A;
      bus8.start        = 1'b1;
      tick();
      bus8.start = 1'b0;
      done_cnt = (bus8.done) ? 1 : 0;
      for (int c = 1; c < 5; c++) begin
         tick();
         if (bus8.done) done_cnt++;
      end
      rst_b = 1'b0;
      tick();
      rst_b = 1'b1;
      check("mid_rst_rdy",  64'(bus8.rdy),     64'(1));
      check("mid_rst_prod", 64'(bus8.product), 64'(0));
      for (int c = 0; c < 30; c++) begin
         if (bus8.done) done_cnt++;
         tick();
      end
      check("mid_rst_nodone", 64'(done_cnt), 64'(0));

      bus8.signed_mode  = 1'b0;
      bus8.multiplicand = 8'd3;
      bus8.multiplier   = 8'd4;
      bus8.start        = 1'b1;
      tick();
      bus8.start = 1'b0;
      lat = 1;
      while (!bus8.done && lat < 100) begin
         tick();
         lat++;
      end
      check("post_rst_lat",  64'(lat),          64'(17));
      check("post_rst_prod", 64'(bus8.product), 64'(16'h000C));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
